// File: rtl/alarm_pkg.sv
// Shared alarm constants, state encodings and small helpers.
// Snooze support is selected by the ALARM_SNOOZE_EN macro in the top.
package alarm_pkg;

  localparam int unsigned HR_MAX         = 23;
  localparam int unsigned MIN_MAX        = 59;
  localparam int unsigned SEC_PER_MIN    = 60;
  localparam int unsigned RING_TIMEOUT_S = 60;
  localparam int unsigned SNOOZE_MIN     = 5;
  localparam int unsigned MAX_SNOOZE     = 3;
  localparam int unsigned SET_TIMEOUT_S  = 30;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_SNOOZE  = 3'd3,
    ST_SET_HR  = 3'd4,
    ST_SET_MIN = 3'd5
  } state_e;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic is_set(input state_e s);
    return (s == ST_SET_HR) || (s == ST_SET_MIN);
  endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable sec_tick down-counter; done_c flags the tick that empties it.
module alarm_sec_timer #(
  parameter int unsigned PERIOD = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic done_c
);

  localparam int unsigned W = $clog2(PERIOD + 1);

  logic [W-1:0] count;

  // Load wins over a coincident tick; stops at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(PERIOD);
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done_c = tick && (count == W'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm time registers and set/arm/ring/snooze/stop lifecycle.
// Define ALARM_SNOOZE_EN to build the snooze state; otherwise btn_snooze acts as btn_stop.
module alarm_sequencer
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       btn_set,
  input  logic       btn_hr_inc,
  input  logic       btn_min_inc,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  input  logic       sw_en,
  input  logic [5:0] c_hour,
  input  logic [5:0] c_min,
  input  logic [5:0] c_sec,
  output logic [5:0] a_hr,
  output logic [5:0] a_min,
  output logic       set_mode,
  output logic       ringing,
  output logic       buzz,
  output logic       snoozed,
  output logic [2:0] state
);

  state_e     state_q;
  state_e     state_nx;
  logic [5:0] a_hr_nx;
  logic [5:0] a_min_nx;
  logic       buzz_nx;
  logic       match_c;
  logic       any_btn_c;
  logic       stop_req_c;
  logic       set_exit_c;
  logic       ring_done;
  logic       set_done;
  logic       ring_load;
  logic       set_load;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_SEC = SNOOZE_MIN * SEC_PER_MIN;
  localparam int unsigned USED_W  = $clog2(MAX_SNOOZE + 1);

  logic [USED_W-1:0] snooze_used;
  logic [USED_W-1:0] used_nx;
  logic              snz_done;
  logic              snz_load;

  assign stop_req_c = btn_stop;
`else
  assign stop_req_c = btn_stop | btn_snooze;
`endif

  assign match_c   = sec_tick && (c_hour == a_hr) && (c_min == a_min) && (c_sec == 6'd0);
  assign any_btn_c = btn_set | btn_hr_inc | btn_min_inc | btn_stop | btn_snooze;

  // A button in the timeout cycle restarts the timer, so it cancels the exit.
  assign set_exit_c = set_done && !any_btn_c;

  // Next state and next register values.
  always_comb begin
    state_nx = state_q;
    a_hr_nx  = a_hr;
    a_min_nx = a_min;
`ifdef ALARM_SNOOZE_EN
    used_nx  = snooze_used;
`endif
    case (state_q)
      ST_IDLE: begin
        if (btn_set)    state_nx = ST_SET_HR;
        else if (sw_en) state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        if (!sw_en)        state_nx = ST_IDLE;
        else if (btn_set)  state_nx = ST_SET_HR;
        else if (match_c) begin
          state_nx = ST_RINGING;
`ifdef ALARM_SNOOZE_EN
          used_nx  = '0;
`endif
        end
      end
      ST_RINGING: begin
        if (!sw_en)          state_nx = ST_IDLE;
        else if (stop_req_c) state_nx = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
        else if (btn_snooze) begin
          if (snooze_used < USED_W'(MAX_SNOOZE)) begin
            state_nx = ST_SNOOZE;
            used_nx  = snooze_used + USED_W'(1);
          end else begin
            state_nx = ST_ARMED;
          end
        end
`endif
        else if (ring_done)  state_nx = ST_ARMED;
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (!sw_en)         state_nx = ST_IDLE;
        else if (btn_stop)  state_nx = ST_ARMED;
        else if (snz_done)  state_nx = ST_RINGING;
      end
`endif
      ST_SET_HR: begin
        if (btn_hr_inc) a_hr_nx = wrap_inc(a_hr, 6'(HR_MAX));
        if (btn_set)    state_nx = ST_SET_MIN;
        else if (set_exit_c) state_nx = sw_en ? ST_ARMED : ST_IDLE;
      end
      ST_SET_MIN: begin
        if (btn_min_inc) a_min_nx = wrap_inc(a_min, 6'(MIN_MAX));
        if (btn_set || set_exit_c) state_nx = sw_en ? ST_ARMED : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    buzz_nx = ((state_q == ST_RINGING) && (state_nx == ST_RINGING)) ? (buzz ^ sec_tick) : 1'b0;
  end

  assign ring_load = (state_nx == ST_RINGING) && (state_q != ST_RINGING);
  assign set_load  = is_set(state_nx) && (!is_set(state_q) || any_btn_c);

  alarm_sec_timer #(.PERIOD(RING_TIMEOUT_S)) u_ring_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ring_load),
    .tick   (sec_tick),
    .done_c (ring_done)
  );

  alarm_sec_timer #(.PERIOD(SET_TIMEOUT_S)) u_set_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (set_load),
    .tick   (sec_tick),
    .done_c (set_done)
  );

`ifdef ALARM_SNOOZE_EN
  assign snz_load = (state_nx == ST_SNOOZE) && (state_q != ST_SNOOZE);

  alarm_sec_timer #(.PERIOD(SNZ_SEC)) u_snz_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (snz_load),
    .tick   (sec_tick),
    .done_c (snz_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snooze_used <= '0;
      snoozed     <= 1'b0;
    end else begin
      snooze_used <= used_nx;
      snoozed     <= (state_nx == ST_SNOOZE);
    end
  end
`else
  assign snoozed = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_hr     <= '0;
      a_min    <= '0;
      set_mode <= 1'b0;
      ringing  <= 1'b0;
      buzz     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      a_hr     <= a_hr_nx;
      a_min    <= a_min_nx;
      set_mode <= is_set(state_nx);
      ringing  <= (state_nx == ST_RINGING);
      buzz     <= buzz_nx;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: vector table plus hand-written lifecycle sequences.
module tb_alarm_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RING = 3'd2,
                         S_SNZ  = 3'd3, S_SHR = 3'd4, S_SMN  = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sec_tick, btn_set, btn_hr_inc, btn_min_inc, btn_stop, btn_snooze, sw_en;
  logic [5:0] c_hour, c_min, c_sec;
  logic [5:0] a_hr, a_min;
  logic       set_mode, ringing, buzz, snoozed;
  logic [2:0] state;

  always #5 clk = ~clk;

  alarm_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sec_tick    (sec_tick),
    .btn_set     (btn_set),
    .btn_hr_inc  (btn_hr_inc),
    .btn_min_inc (btn_min_inc),
    .btn_stop    (btn_stop),
    .btn_snooze  (btn_snooze),
    .sw_en       (sw_en),
    .c_hour      (c_hour),
    .c_min       (c_min),
    .c_sec       (c_sec),
    .a_hr        (a_hr),
    .a_min       (a_min),
    .set_mode    (set_mode),
    .ringing     (ringing),
    .buzz        (buzz),
    .snoozed     (snoozed),
    .state       (state)
  );

  typedef struct {
    logic set, hr, mn, stop, snz, tick, en;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] hr;
    logic [5:0] mn;
    logic       sm, rg, sz, bz;
  } exp_t;

  typedef struct {
    string nm;
    in_t   i;
    exp_t  e;
  } vec_t;

  exp_t  exp_q[$];
  string nm_q[$];
  vec_t  tbl[$];
  int    errors = 0;
  int    checks = 0;

  function automatic in_t mk_in(input logic set, hr, mn, stop, snz, tick, en);
    in_t r;
    r.set = set; r.hr = hr; r.mn = mn; r.stop = stop; r.snz = snz; r.tick = tick; r.en = en;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [2:0] st, input logic [5:0] hr, mn, input logic bz);
    exp_t r;
    r.st = st; r.hr = hr; r.mn = mn;
    r.sm = (st == S_SHR) || (st == S_SMN);
    r.rg = (st == S_RING);
    r.sz = (st == S_SNZ);
    r.bz = bz;
    return r;
  endfunction

  function automatic vec_t mk_vec(input string nm, input in_t i, input exp_t e);
    vec_t r;
    r.nm = nm; r.i = i; r.e = e;
    return r;
  endfunction

  task automatic check_out();
    exp_t  e;
    exp_t  got;
    string nm;
    e   = exp_q.pop_front();
    nm  = nm_q.pop_front();
    got = {state, a_hr, a_min, set_mode, ringing, snoozed, buzz};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d hr=%0d min=%0d sm/rg/sz/bz=%b%b%b%b, want st=%0d hr=%0d min=%0d sm/rg/sz/bz=%b%b%b%b",
               nm, got.st, got.hr, got.mn, got.sm, got.rg, got.sz, got.bz,
               e.st, e.hr, e.mn, e.sm, e.rg, e.sz, e.bz);
    end
  endtask

  task automatic check_now(input exp_t e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    check_out();
  endtask

  // Drive one cycle of inputs, queue the expectation, compare just after the edge.
  task automatic apply(input in_t i, input exp_t e, input string nm);
    btn_set = i.set; btn_hr_inc = i.hr; btn_min_inc = i.mn;
    btn_stop = i.stop; btn_snooze = i.snz; sec_tick = i.tick; sw_en = i.en;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    btn_set = 1'b0; btn_hr_inc = 1'b0; btn_min_inc = 1'b0;
    btn_stop = 1'b0; btn_snooze = 1'b0; sec_tick = 1'b0;
    check_out();
  endtask

  task automatic step(input logic set, hr, mn, stop, snz, tick, en,
                      input logic [2:0] st, input logic [5:0] ehr, emn,
                      input logic bz, input string nm);
    apply(mk_in(set, hr, mn, stop, snz, tick, en), mk_exp(st, ehr, emn, bz), nm);
  endtask

  task automatic set_time(input int h, m, s);
    c_hour = 6'(h); c_min = 6'(m); c_sec = 6'(s);
  endtask

  initial begin
    rst_n = 1'b0;
    sec_tick = 1'b0; btn_set = 1'b0; btn_hr_inc = 1'b0; btn_min_inc = 1'b0;
    btn_stop = 1'b0; btn_snooze = 1'b0; sw_en = 1'b0;
    set_time(0, 0, 0);

    // Set flow table: 07:30 entered with sw_en low, then enabled.
    tbl.push_back(mk_vec("enter_set_hr", mk_in(1,0,0,0,0,0,0), mk_exp(S_SHR, 0, 0, 0)));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk_vec("hr_inc", mk_in(0,1,0,0,0,0,0), mk_exp(S_SHR, 6'(k), 0, 0)));
    tbl.push_back(mk_vec("to_set_min", mk_in(1,0,0,0,0,0,0), mk_exp(S_SMN, 7, 0, 0)));
    for (int k = 1; k <= 30; k++)
      tbl.push_back(mk_vec("min_inc", mk_in(0,0,1,0,0,0,0), mk_exp(S_SMN, 7, 6'(k), 0)));
    tbl.push_back(mk_vec("exit_set_idle", mk_in(1,0,0,0,0,0,0), mk_exp(S_IDLE, 7, 30, 0)));
    tbl.push_back(mk_vec("arm", mk_in(0,0,0,0,0,0,1), mk_exp(S_ARM, 7, 30, 0)));
    tbl.push_back(mk_vec("armed_hold", mk_in(0,0,0,0,0,0,1), mk_exp(S_ARM, 7, 30, 0)));

    repeat (3) @(posedge clk);
    #1;
    check_now(mk_exp(S_IDLE, 0, 0, 0), "reset_state");
    rst_n = 1'b1;
    step(0,0,0,0,0,0,0, S_IDLE, 0, 0, 0, "post_reset_idle");

    foreach (tbl[n]) apply(tbl[n].i, tbl[n].e, tbl[n].nm);

    // Trigger at 07:30:00, buzz toggles, auto-stop after 60 ticks.
    set_time(7, 30, 0);
    step(0,0,0,0,0,1,1, S_RING, 7, 30, 0, "trigger");
    for (int k = 1; k <= 59; k++) begin
      set_time(7, 30, k);
      step(0,0,0,0,0,1,1, S_RING, 7, 30, 1'(k % 2), "ring_tick");
    end
    set_time(7, 31, 0);
    step(0,0,0,0,0,1,1, S_ARM, 7, 30, 0, "ring_timeout");
    set_time(7, 30, 59);
    step(0,0,0,0,0,1,1, S_ARM, 7, 30, 0, "no_retrigger_59");

    // Stop, then snooze behaviour.
    set_time(7, 30, 0);
    step(0,0,0,0,0,1,1, S_RING, 7, 30, 0, "retrigger");
    step(1,1,1,0,0,0,1, S_RING, 7, 30, 0, "set_ignored_ringing");
    step(0,0,0,1,0,0,1, S_ARM, 7, 30, 0, "stop");
    step(0,0,0,0,0,1,1, S_RING, 7, 30, 0, "trigger_snz");
`ifdef ALARM_SNOOZE_EN
    for (int s = 1; s <= 3; s++) begin
      step(0,0,0,0,1,0,1, S_SNZ, 7, 30, 0, "snooze");
      for (int k = 1; k < 300; k++)
        step(0,0,0,0,0,1,1, S_SNZ, 7, 30, 0, "snooze_tick");
      step(0,0,0,0,0,1,1, S_RING, 7, 30, 0, "snooze_expire");
    end
    step(0,0,0,0,1,0,1, S_ARM, 7, 30, 0, "fourth_snooze_stops");
`else
    step(0,0,0,0,1,0,1, S_ARM, 7, 30, 0, "snooze_as_stop");
`endif

    // Same-cycle priority.
    step(0,0,0,0,0,1,1, S_RING, 7, 30, 0, "trigger_prio");
    step(0,0,0,0,1,0,0, S_IDLE, 7, 30, 0, "en_low_beats_snooze");
    step(0,0,0,0,0,0,1, S_ARM, 7, 30, 0, "rearm");
    step(0,0,0,0,0,1,1, S_RING, 7, 30, 0, "trigger_prio2");
    step(0,0,0,1,1,0,1, S_ARM, 7, 30, 0, "stop_beats_snooze");

    // Wrap in both fields; sw_en low during set mode is applied only on exit.
    set_time(12, 0, 0);
    step(1,0,0,0,0,0,1, S_SHR, 7, 30, 0, "enter_set_wrap");
    for (int k = 8; k <= 23; k++)
      step(0,1,0,0,0,0,0, S_SHR, 6'(k), 30, 0, "hr_inc_en_low");
    step(1,1,0,0,0,0,0, S_SMN, 0, 30, 0, "hr_wrap_with_set");
    for (int k = 31; k <= 59; k++)
      step(0,0,1,0,0,0,0, S_SMN, 0, 6'(k), 0, "min_inc_en_low");
    step(1,0,1,0,0,0,0, S_IDLE, 0, 0, 0, "min_wrap_exit");
    step(0,0,0,0,0,0,1, S_ARM, 0, 0, 0, "arm_after_wrap");

    // Set timeout with restart, edits kept.
    step(1,0,0,0,0,0,1, S_SHR, 0, 0, 0, "enter_set_to");
    for (int k = 1; k <= 5; k++)
      step(0,1,0,0,0,0,1, S_SHR, 6'(k), 0, 0, "hr_inc_to");
    step(1,0,0,0,0,0,1, S_SMN, 5, 0, 0, "to_min_to");
    for (int k = 1; k <= 2; k++)
      step(0,0,1,0,0,0,1, S_SMN, 5, 6'(k), 0, "min_inc_to");
    for (int k = 1; k <= 20; k++)
      step(0,0,0,0,0,1,0, S_SMN, 5, 2, 0, "set_idle_tick");
    step(0,0,1,0,0,0,0, S_SMN, 5, 3, 0, "restart_timeout");
    for (int k = 1; k <= 29; k++)
      step(0,0,0,0,0,1,0, S_SMN, 5, 3, 0, "set_idle_tick2");
    step(0,0,0,0,0,1,0, S_IDLE, 5, 3, 0, "set_timeout_exit");
    step(0,0,0,0,0,0,1, S_ARM, 5, 3, 0, "arm_after_timeout");

    // Asynchronous reset mid-ring or mid-snooze.
    set_time(5, 3, 0);
    step(0,0,0,0,0,1,1, S_RING, 5, 3, 0, "trigger_rst");
`ifdef ALARM_SNOOZE_EN
    step(0,0,0,0,1,0,1, S_SNZ, 5, 3, 0, "snooze_before_rst");
`endif
    rst_n = 1'b0;
    #2;
    check_now(mk_exp(S_IDLE, 0, 0, 0), "async_reset_mid");
    sw_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0,0,0,0,0,0,0, S_IDLE, 0, 0, 0, "after_reset_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
